gcd_requester: RTL and testbench
================================

// Module: gcd_requester
// PURPOSE
//  Initiator side of the gcd start/done handshake. Accepts operand pairs on a
//  valid/ready input stream and issues each pair to a gcd core as a one-cycle
//  start with held operands. It waits for the core's done pulse and returns the
//  result on a valid/ready output stream. A watchdog flags a core that never
//  completes. Sits between the system fabric and the gcd datapath.
// PARAMETERS
//  WIDTH    8     operand/result width; must match the attached gcd core
//  TIMEOUT  1023  max cycles in WAIT before an op is abandoned; must be >= 1
//  CNTW     10    watchdog counter width; 2**CNTW must be > TIMEOUT
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand pair valid
//  in_ready    out  1      requester can accept a pair (high only in IDLE)
//  in_a        in   WIDTH  operand a
//  in_b        in   WIDTH  operand b
//  out_valid   out  1      response valid
//  out_ready   in   1      consumer accepts response
//  out_result  out  WIDTH  gcd result (0 on timeout)
//  out_timeout out  1      response was produced by the watchdog
//  gcd_start   out  1      to core: one-cycle start pulse
//  gcd_a       out  WIDTH  to core: operand a, registered, stable from ISSUE to end of op
//  gcd_b       out  WIDTH  to core: operand b, registered, stable from ISSUE to end of op
//  gcd_outp    in   WIDTH  from core: result, valid while gcd_done=1
//  gcd_done    in   1      from core: one-cycle completion pulse
//  busy        out  1      high in ISSUE, WAIT and RESP
//  ops_count   out  16     completed responses (normal + timeout), saturates at 0xFFFF
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. All outputs are 0 except in_ready=1.
//   gcd_a/gcd_b, watchdog and ops_count are 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered or
//   decoded from state only. No combinational path from in_* to out_*.
//  IDLE: in_ready=1. On in_valid&in_ready, capture in_a/in_b into gcd_a/gcd_b
//   and go to ISSUE.
//  ISSUE: gcd_start=1 for exactly this cycle. Clear watchdog. Go to WAIT.
//  WAIT: each cycle without gcd_done, watchdog += 1.
//   - gcd_done=1: out_result<=gcd_outp, out_timeout<=0, go to RESP.
//   - watchdog==TIMEOUT and no done: out_result<=0, out_timeout<=1, go to RESP.
//   - done and watchdog==TIMEOUT in the same cycle: done wins, out_timeout=0.
//  RESP: out_valid=1. out_result/out_timeout are held stable until out_valid&out_ready.
//   On the handshake: return to IDLE, ops_count += 1 (saturating).
//   in_ready=0 throughout, so back-pressure stalls the input.
//  gcd_done seen in IDLE, ISSUE or RESP (e.g. a late done after a timeout) is
//   ignored. It does not alter out_* or ops_count.
//  Zero operands are forwarded unchanged. The core's result (0) is returned.
//  Latency: input handshake at edge k -> gcd_start high in cycle k+1 ->
//   out_valid high in the cycle after gcd_done is sampled.
//  Throughput: one op in flight; no new pair is accepted before the response is taken.
//  Reset mid-operation: returns to IDLE at once and drops gcd_start. Any
//   in-flight result is discarded. The attached core shares the reset.
// TESTING
//  1. in_a=48,in_b=18 with a real gcd core -> one gcd_start pulse, gcd_a/b held
//     at 48/18, out_result=6, out_timeout=0, ops_count=1.
//  2. in_a=0,in_b=5 -> out_result=0, out_timeout=0. Then in_a=255,in_b=1 ->
//     out_result=1, the worst-case iteration count, completes before TIMEOUT.
//  3. out_ready low for 10 cycles in RESP (pair 12,18) -> out_valid held,
//     out_result=6 stable, in_ready=0. Second pair not accepted until release.
//  4. TIMEOUT=15, core model never asserts done -> out_valid 16 cycles after
//     the WAIT entry, out_result=0, out_timeout=1. A late done in IDLE is ignored.
//  5. Core model pulses done exactly when watchdog==TIMEOUT (result 7) ->
//     out_result=7, out_timeout=0.
//  6. Assert reset during WAIT -> all outputs at reset values asynchronously.
//     After release, pair 21,14 -> out_result=7, ops_count=1.

Source files
------------

// File: rtl/gcd_requester.sv
// -----------------------------------------------------------------------------
// gcd_requester
//   Initiator side of the gcd start/done handshake. An operand pair accepted on
//   the input stream is registered onto gcd_a/gcd_b, a one-cycle gcd_start is
//   issued, and the requester waits for gcd_done. The core's result, or a
//   zero result flagged by the watchdog, is then offered on the output stream.
//   Only one operation is in flight at a time.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
//   where valid and ready are both high. valid never depends combinationally
//   on ready. Every output is either a flop or a pure decode of the state.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     operand pair valid
//   in_ready     pair can be accepted (IDLE only)
//   in_a, in_b   operands
//   out_valid    response valid (RESP only)
//   out_ready    consumer accepts the response
//   out_result   gcd result, 0 on timeout
//   out_timeout  response was produced by the watchdog
//   gcd_start    one-cycle start pulse to the core
//   gcd_a, gcd_b registered operands to the core, held for the whole op
//   gcd_outp     core result, valid while gcd_done is high
//   gcd_done     core one-cycle completion pulse
//   busy         high in ISSUE, WAIT and RESP
//   ops_count    completed responses, saturating at 16'hFFFF
//   dbg_state    current FSM state for observation
//
// Parameters
//   WIDTH    operand/result width, must match the attached core
//   TIMEOUT  watchdog limit in WAIT cycles, >= 1
//   CNTW     watchdog counter width, 2**CNTW > TIMEOUT
// -----------------------------------------------------------------------------
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023,
  parameter int CNTW    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_timeout,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic [WIDTH-1:0] gcd_outp,
  input  logic             gcd_done,
  output logic             busy,
  output logic [15:0]      ops_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] WD_LIMIT = CNTW'(TIMEOUT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gcd_a_q, gcd_a_d;
  logic [WIDTH-1:0] gcd_b_q, gcd_b_d;
  logic [CNTW-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      ops_q, ops_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gcd_a_q   <= '0;
      gcd_b_q   <= '0;
      wd_q      <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      gcd_a_q   <= gcd_a_d;
      gcd_b_q   <= gcd_b_d;
      wd_q      <= wd_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      ops_q     <= ops_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gcd_a_d   = gcd_a_q;
    gcd_b_d   = gcd_b_q;
    wd_d      = wd_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    ops_d     = ops_q;
    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (in_valid) begin
          gcd_a_d = in_a;
          gcd_b_d = in_b;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving in the same cycle the watchdog expires still wins.
        if (gcd_done) begin
          result_d  = gcd_outp;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (wd_q == WD_LIMIT) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wd_d = wd_q + CNTW'(1);
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          if (ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are pure state decodes; gcd_done outside WAIT has no effect.
  assign in_ready    = (state_q == ST_IDLE);
  assign gcd_start   = (state_q == ST_ISSUE);
  assign out_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign gcd_a       = gcd_a_q;
  assign gcd_b       = gcd_b_q;
  assign out_result  = result_q;
  assign out_timeout = timeout_q;
  assign ops_count   = ops_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gcd_requester.sv
module tb_gcd_requester;

  localparam int W       = 8;
  localparam int TIMEOUT = 1023;
  localparam int CNTW    = 10;

  // core model modes
  localparam int M_NORMAL = 0;  // done after the subtraction iteration count
  localparam int M_NEVER  = 1;  // done never arrives
  localparam int M_FIXED  = 2;  // done after core_lat cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_timeout, gcd_start, busy;
  logic [W-1:0] out_result, gcd_a, gcd_b;
  logic [W-1:0] gcd_outp;
  logic         gcd_done;
  logic [15:0]  ops_count;
  logic [1:0]   dbg_state;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_outp(gcd_outp), .gcd_done(gcd_done),
    .busy(busy), .ops_count(ops_count), .dbg_state(dbg_state)
  );

  // ---------------- gcd core model ----------------
  int           core_mode = M_NORMAL;
  int           core_lat  = 1;
  int           core_lat_used = 0;
  int           core_cnt = 0;
  logic [W-1:0] core_res = '0;
  int           inj_req = 0, inj_ack = 0;
  logic [W-1:0] inj_val = '0;
  int           m_steps;
  logic [W-1:0] m_res;

  // Iterative subtraction core; zero operands yield 0 after one cycle.
  task automatic sub_gcd(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output int steps);
    steps = 0;
    if (a == 0 || b == 0) begin
      r = '0;
      steps = 1;
    end else begin
      while (a != b) begin
        if (a > b) a = a - b; else b = b - a;
        steps++;
      end
      r = a;
      if (steps < 1) steps = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_done <= 1'b0;
      gcd_outp <= '0;
      core_cnt <= 0;
    end else begin
      gcd_done <= 1'b0;
      if (inj_req != inj_ack) begin
        inj_ack  <= inj_req;
        gcd_done <= 1'b1;
        gcd_outp <= inj_val;
      end else if (gcd_start) begin
        sub_gcd(gcd_a, gcd_b, m_res, m_steps);
        core_res <= m_res;
        if (core_mode == M_FIXED) m_steps = core_lat;
        core_lat_used <= m_steps;
        core_cnt <= (core_mode == M_NEVER) ? 0 : m_steps;
      end else if (core_cnt == 1) begin
        gcd_done <= 1'b1;
        gcd_outp <= core_res;
        core_cnt <= 0;
      end else if (core_cnt > 1) begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Mathematical gcd by remainder; a zero operand makes the core return 0.
  function automatic logic [W-1:0] ref_gcd(input int a, input int b);
    int t;
    if (a == 0 || b == 0) return '0;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return W'(a);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;
  int exp_ops = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mode, input int lat, input int hold,
                       input logic exp_tmo, input string name);
    int cyc, starts, exp_lat;
    logic [W-1:0] exp_res;
    exp_q.push_back(exp_tmo ? '0 : ref_gcd(int'(a), int'(b)));
    core_mode = mode;
    core_lat  = lat;
    @(negedge clk);
    chk({name, " in_ready idle"}, in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, " start"}, gcd_start, 1);
    chk({name, " gcd_a"}, gcd_a, a);
    chk({name, " gcd_b"}, gcd_b, b);
    chk({name, " busy"}, busy, 1);
    chk({name, " in_ready busy"}, in_ready, 0);
    cyc = 0;
    starts = 1;
    while (!out_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gcd_start) starts++;
      if (gcd_a !== a || gcd_b !== b) begin
        chk({name, " operands held"}, {gcd_a, gcd_b}, {a, b});
      end
    end
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " start pulses"}, starts, 1);
    if (mode == M_NEVER) exp_lat = TIMEOUT + 2;
    else exp_lat = ((core_lat_used < TIMEOUT) ? core_lat_used : TIMEOUT) + 2;
    chk({name, " latency"}, cyc, exp_lat);
    exp_res = exp_q.pop_front();
    chk({name, " result"}, out_result, exp_res);
    chk({name, " timeout"}, out_timeout, exp_tmo);
    // back-pressure: a competing pair must not be taken
    for (int h = 0; h < hold; h++) begin
      in_a = a + 8'd1; in_b = b + 8'd1; in_valid = 1'b1;
      @(negedge clk);
      chk({name, " hold valid"}, out_valid, 1);
      chk({name, " hold result"}, out_result, exp_res);
      chk({name, " hold in_ready"}, in_ready, 0);
      chk({name, " hold gcd_a"}, gcd_a, a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_ops < 16'hFFFF) exp_ops++;
    chk({name, " ops_count"}, ops_count, exp_ops);
    chk({name, " released"}, out_valid, 0);
    chk({name, " idle again"}, in_ready, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a, b;
    int           mode, lat, hold;
    logic [W-1:0] res;
    logic         tmo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'd48,  8'd18, M_NORMAL, 0,           0,  8'd6,  1'b0};
    tbl[1] = '{8'd0,   8'd5,  M_NORMAL, 0,           0,  8'd0,  1'b0};
    tbl[2] = '{8'd255, 8'd1,  M_NORMAL, 0,           0,  8'd1,  1'b0};
    tbl[3] = '{8'd12,  8'd18, M_NORMAL, 0,           10, 8'd6,  1'b0};
    tbl[4] = '{8'd9,   8'd6,  M_NEVER,  0,           2,  8'd0,  1'b1};
    tbl[5] = '{8'd21,  8'd14, M_FIXED,  TIMEOUT,     0,  8'd7,  1'b0};
    tbl[6] = '{8'd30,  8'd20, M_FIXED,  TIMEOUT + 1, 1,  8'd0,  1'b1};
    tbl[7] = '{8'd100, 8'd75, M_FIXED,  1,           0,  8'd25, 1'b0};

    // reset state
    #3;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset gcd_start", gcd_start, 0);
    chk("reset busy", busy, 0);
    chk("reset ops_count", ops_count, 0);
    chk("reset gcd_a", gcd_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d table vs ref", i),
          tbl[i].tmo ? 8'd0 : ref_gcd(int'(tbl[i].a), int'(tbl[i].b)), tbl[i].res);
      do_op(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].lat, tbl[i].hold,
            tbl[i].tmo, $sformatf("tbl%0d", i));
    end

    // late done after a timeout: must not touch out_* or ops_count
    do_op(8'd40, 8'd16, M_NEVER, 0, 0, 1'b1, "late_op");
    inj_val = 8'd99;
    inj_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late out_valid", out_valid, 0);
      chk("late out_result", out_result, 0);
      chk("late out_timeout", out_timeout, 1);
      chk("late ops_count", ops_count, exp_ops);
    end
    do_op(8'd8, 8'd12, M_NORMAL, 0, 0, 1'b0, "after_late");

    // randomized operations
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      int md;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      md = ($urandom_range(0, 1) == 0) ? M_NORMAL : M_FIXED;
      do_op(ra, rb, md, $urandom_range(1, 60), $urandom_range(0, 3), 1'b0,
            $sformatf("rnd%0d", i));
    end

    // reset during WAIT
    core_mode = M_NEVER;
    @(negedge clk);
    in_a = 8'd77; in_b = 8'd11; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", in_ready, 1);
    chk("mid reset busy", busy, 0);
    chk("mid reset gcd_start", gcd_start, 0);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset gcd_a", gcd_a, 0);
    chk("mid reset gcd_b", gcd_b, 0);
    chk("mid reset ops_count", ops_count, 0);
    chk("mid reset out_result", out_result, 0);
    chk("mid reset out_timeout", out_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    do_op(8'd21, 8'd14, M_NORMAL, 0, 0, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
